// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: opcodes, funct3 codes, FSM states and access-size helpers shared by the
// memory port arbiter and its access checker.
package mem_arb_pkg;

   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;
   localparam logic [6:0] OPC_NONE  = 7'b0000000;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_RESP} state_e;
   typedef enum logic {SIDE_IF, SIDE_LSU} side_e;

   // Bytes touched by an access; 0 marks the reserved width code.
   function automatic logic [2:0] f3_size(input logic [2:0] f3);
      return f3[1:0] == F3_B[1:0] ? 3'd1 :
             f3[1:0] == F3_H[1:0] ? 3'd2 :
             f3[1:0] == F3_W[1:0] ? 3'd4 : 3'd0;
   endfunction

   function automatic logic [31:0] size_mask(input logic [2:0] size);
      return size == 3'd1 ? 32'h0000_00FF :
             size == 3'd2 ? 32'h0000_FFFF : 32'hFFFF_FFFF;
   endfunction

endpackage

// File: rtl/mem_access_check.sv
// mem_access_check: decides whether an opcode/funct3/address triple is a legal Memory access
// and reports its size in bytes.
module mem_access_check
   import mem_arb_pkg::*;
#(
   parameter int MEM_BYTES = 64
) (
   input  logic [6:0]  opcode_i,
   input  logic [2:0]  funct3_i,
   input  logic [31:0] addr_i,
   output logic        legal_o,
   output logic [2:0]  size_o
);

   logic        op_ok;
   logic        f3_ok;
   logic [32:0] last;

   always_comb begin
      size_o  = f3_size(funct3_i);
      op_ok   = opcode_i == OPC_LOAD || opcode_i == OPC_STORE;
      f3_ok   = size_o != 3'd0 && !(opcode_i == OPC_STORE && funct3_i[2]);
      // 33-bit sum so an access near 2^32 cannot wrap back into range
      last    = {1'b0, addr_i} + 33'(size_o) - 33'd1;
      legal_o = op_ok && f3_ok && last < 33'(MEM_BYTES);
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single Memory port between IF and LSU; LSU has priority, but
// IF is forced through once LSU has won MAX_LSU_STREAK times in a row while IF waited.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int MEM_BYTES      = 64,
   parameter int MAX_LSU_STREAK = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req_valid,
   output logic        if_req_ready,
   input  logic [31:0] if_addr,
   output logic        if_rsp_valid,
   output logic [31:0] if_rsp_data,
   output logic        if_rsp_err,
   input  logic        lsu_req_valid,
   output logic        lsu_req_ready,
   input  logic [6:0]  lsu_opcode,
   input  logic [2:0]  lsu_funct3,
   input  logic [31:0] lsu_addr,
   input  logic [31:0] lsu_wdata,
   output logic        lsu_rsp_valid,
   output logic [31:0] lsu_rsp_data,
   output logic        lsu_rsp_err,
   output logic [6:0]  mem_dp_ctrl,
   output logic [2:0]  mem_funct3,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wr_data,
   input  logic [31:0] mem_rd_data
);

   localparam int            SW         = $clog2(MAX_LSU_STREAK + 1);
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_LSU_STREAK);

   state_e        state_q, state_d;
   side_e         side_q, side_d;
   logic [SW-1:0] streak_q, streak_d;
   logic [6:0]    op_q, op_d;
   logic [2:0]    f3_q, f3_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic          err_q, err_d;
   logic          can_acc, force_if, grant_if, grant_lsu, acc;
   logic          legal, issue_ok, resp;
   logic [2:0]    size;
   logic [31:0]   rd_data;

   // Grant and the winner's fields; IF always issues a word load
   always_comb begin
      can_acc   = !rst && state_q != ST_ISSUE;
      force_if  = if_req_valid && streak_q == STREAK_MAX;
      grant_lsu = can_acc && lsu_req_valid && !force_if;
      grant_if  = can_acc && if_req_valid && !grant_lsu;
      acc       = grant_lsu || grant_if;
      side_d    = grant_lsu ? SIDE_LSU : SIDE_IF;
      op_d      = grant_lsu ? lsu_opcode : OPC_LOAD;
      f3_d      = grant_lsu ? lsu_funct3 : F3_W;
      addr_d    = grant_lsu ? lsu_addr : if_addr;
   end

   mem_access_check #(
      .MEM_BYTES(MEM_BYTES)
   ) u_check (
      .opcode_i(op_d),
      .funct3_i(f3_d),
      .addr_i  (addr_d),
      .legal_o (legal),
      .size_o  (size)
   );

   assign err_d   = !legal;
   assign wdata_d = grant_lsu ? (lsu_wdata & size_mask(size)) : 32'h0;

   always_comb begin
      state_d  = state_q == ST_ISSUE ? ST_RESP : (acc ? ST_ISSUE : ST_IDLE);
      streak_d = (!if_req_valid || grant_if) ? '0 :
                 (grant_lsu && streak_q != STREAK_MAX) ? streak_q + SW'(1) : streak_q;
   end

   assign if_req_ready  = grant_if;
   assign lsu_req_ready = grant_lsu;

   // Everything below is decoded from state, so an async reset silences Memory at once
   always_comb begin
      issue_ok      = state_q == ST_ISSUE && !err_q;
      mem_dp_ctrl   = issue_ok ? op_q : OPC_NONE;
      mem_funct3    = issue_ok ? f3_q : 3'b0;
      mem_addr      = issue_ok ? addr_q : 32'h0;
      mem_wr_data   = issue_ok ? wdata_q : 32'h0;
      resp          = state_q == ST_RESP;
      rd_data       = (resp && !err_q && op_q == OPC_LOAD) ? mem_rd_data : 32'h0;
      if_rsp_valid  = resp && side_q == SIDE_IF;
      lsu_rsp_valid = resp && side_q == SIDE_LSU;
      if_rsp_data   = if_rsp_valid ? rd_data : 32'h0;
      lsu_rsp_data  = lsu_rsp_valid ? rd_data : 32'h0;
      if_rsp_err    = if_rsp_valid && err_q;
      lsu_rsp_err   = lsu_rsp_valid && err_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         streak_q <= '0;
         side_q   <= SIDE_IF;
         op_q     <= OPC_NONE;
         f3_q     <= 3'b0;
         addr_q   <= 32'h0;
         wdata_q  <= 32'h0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         streak_q <= streak_d;
         if (acc) begin
            side_q  <= side_d;
            op_q    <= op_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: drives the arbiter with a behavioural byte Memory behind it and checks
// responses against vector tables, hand sequences and a byte-array reference model.
module tb_mem_port_arbiter;

   localparam logic [6:0] OL = 7'b0000011;
   localparam logic [6:0] OS = 7'b0100011;

   typedef struct {
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] exp_d;
      logic        exp_e;
      logic [6:0]  exp_dp;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        if_req_valid = 1'b0;
   logic        if_req_ready;
   logic [31:0] if_addr = 32'h0;
   logic        if_rsp_valid;
   logic [31:0] if_rsp_data;
   logic        if_rsp_err;
   logic        lsu_req_valid = 1'b0;
   logic        lsu_req_ready;
   logic [6:0]  lsu_opcode = 7'h0;
   logic [2:0]  lsu_funct3 = 3'h0;
   logic [31:0] lsu_addr = 32'h0;
   logic [31:0] lsu_wdata = 32'h0;
   logic        lsu_rsp_valid;
   logic [31:0] lsu_rsp_data;
   logic        lsu_rsp_err;
   logic [6:0]  mem_dp_ctrl;
   logic [2:0]  mem_funct3;
   logic [31:0] mem_addr;
   logic [31:0] mem_wr_data;
   logic [31:0] mem_rd_data;

   int checks = 0;
   int failures = 0;

   logic [7:0]   mem [0:63];
   byte unsigned ref_mem [0:63];
   vec_t         vt [0:19];

   always #5 clk = ~clk;

   mem_port_arbiter #(.MEM_BYTES(64), .MAX_LSU_STREAK(4)) dut (
      .clk(clk), .rst(rst),
      .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
      .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data), .if_rsp_err(if_rsp_err),
      .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_opcode(lsu_opcode),
      .lsu_funct3(lsu_funct3), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
      .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_data(lsu_rsp_data), .lsu_rsp_err(lsu_rsp_err),
      .mem_dp_ctrl(mem_dp_ctrl), .mem_funct3(mem_funct3), .mem_addr(mem_addr),
      .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
   );

   // Memory: little-endian bytes, registered read data extended per funct3
   function automatic logic [31:0] ld_val(input logic [2:0] f3, input logic [31:0] w);
      case (f3)
         3'b000:  return {{24{w[7]}}, w[7:0]};
         3'b001:  return {{16{w[15]}}, w[15:0]};
         3'b100:  return {24'h0, w[7:0]};
         3'b101:  return {16'h0, w[15:0]};
         default: return w;
      endcase
   endfunction

   initial for (int i = 0; i < 64; i++) mem[i] <= 8'h00;

   always @(posedge clk) begin
      if (mem_dp_ctrl == OS) begin
         mem[mem_addr[5:0]] <= mem_wr_data[7:0];
         if (mem_funct3[1:0] != 2'b00) mem[mem_addr[5:0] + 6'd1] <= mem_wr_data[15:8];
         if (mem_funct3[1:0] == 2'b10) begin
            mem[mem_addr[5:0] + 6'd2] <= mem_wr_data[23:16];
            mem[mem_addr[5:0] + 6'd3] <= mem_wr_data[31:24];
         end
      end else if (mem_dp_ctrl == OL) begin
         mem_rd_data <= ld_val(mem_funct3, {mem[mem_addr[5:0] + 6'd3], mem[mem_addr[5:0] + 6'd2],
                                            mem[mem_addr[5:0] + 6'd1], mem[mem_addr[5:0]]});
      end
   end

   // Reference: legality and data straight from the access rules, on a plain byte array
   function automatic void ref_access(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] wd, output logic [31:0] d, output logic e);
      int          sz;
      longint      last;
      int unsigned u;
      sz   = f3[1:0] == 2'b00 ? 1 : f3[1:0] == 2'b01 ? 2 : f3[1:0] == 2'b10 ? 4 : 0;
      last = longint'({32'h0, a}) + sz - 1;
      e    = !(op == OL || op == OS) || sz == 0 || (op == OS && f3[2]) || last >= 64;
      d    = 32'h0;
      u    = 0;
      if (!e && op == OS)
         for (int i = 0; i < sz; i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
      if (!e && op == OL) begin
         for (int i = 0; i < sz; i++) u = u + (32'(ref_mem[int'(a) + i]) << (8 * i));
         if (!f3[2] && sz < 4 && u >= (32'd1 << (8 * sz - 1))) u = u - (32'd1 << (8 * sz));
         d = u;
      end
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // One request on one side; returns response data/err and the ISSUE-cycle mem_dp_ctrl
   task automatic do_txn(input bit is_if, input logic [6:0] op, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] d, output logic e, output logic [6:0] dpc);
      int n = 0;
      @(negedge clk);
      if (is_if) begin
         if_req_valid = 1'b1;
         if_addr      = a;
      end else begin
         lsu_req_valid = 1'b1;
         lsu_opcode    = op;
         lsu_funct3    = f3;
         lsu_addr      = a;
         lsu_wdata     = wd;
      end
      #1;
      while (!(is_if ? if_req_ready : lsu_req_ready) && n < 10) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("accept_within_bound", n < 10, 1);
      @(negedge clk);
      if_req_valid  = 1'b0;
      lsu_req_valid = 1'b0;
      #1;
      dpc = mem_dp_ctrl;
      check("no_rsp_in_issue", if_rsp_valid | lsu_rsp_valid, 0);
      @(negedge clk);
      #1;
      check("rsp_valid_side", is_if ? if_rsp_valid : lsu_rsp_valid, 1);
      check("rsp_other_side", is_if ? lsu_rsp_valid : if_rsp_valid, 0);
      check("dp_idle_in_resp", mem_dp_ctrl, 0);
      d = is_if ? if_rsp_data : lsu_rsp_data;
      e = is_if ? if_rsp_err : lsu_rsp_err;
   endtask

   initial begin
      logic [31:0] d, ed, rwd, ra;
      logic        e, ee;
      logic [6:0]  dpc, rop;
      logic [2:0]  rf3;
      bit          rif;
      int          gcount, cyc;
      for (int i = 0; i < 64; i++) ref_mem[i] = 8'h00;
      vt = '{
         '{OS, 3'b010, 32'd8,  32'hDEADBEEF, 32'h0,        1'b0, OS},
         '{OL, 3'b010, 32'd8,  32'h0,        32'hDEADBEEF, 1'b0, OL},
         '{OS, 3'b000, 32'd3,  32'h00000080, 32'h0,        1'b0, OS},
         '{OL, 3'b000, 32'd3,  32'h0,        32'hFFFFFF80, 1'b0, OL},
         '{OL, 3'b100, 32'd3,  32'h0,        32'h00000080, 1'b0, OL},
         '{OS, 3'b001, 32'd10, 32'h1234ABCD, 32'h0,        1'b0, OS},
         '{OL, 3'b001, 32'd10, 32'h0,        32'hFFFFABCD, 1'b0, OL},
         '{OL, 3'b101, 32'd10, 32'h0,        32'h0000ABCD, 1'b0, OL},
         '{OS, 3'b010, 32'd0,  32'h01020304, 32'h0,        1'b0, OS},
         '{OL, 3'b010, 32'd0,  32'h0,        32'h01020304, 1'b0, OL},
         '{OS, 3'b010, 32'd60, 32'hCAFEF00D, 32'h0,        1'b0, OS},
         '{OL, 3'b010, 32'd62, 32'h0,        32'h0,        1'b1, 7'h0},
         '{OS, 3'b100, 32'd62, 32'hFFFFFFFF, 32'h0,        1'b1, 7'h0},
         '{OL, 3'b101, 32'd62, 32'h0,        32'h0000CAFE, 1'b0, OL},
         '{OL, 3'b000, 32'd63, 32'h0,        32'hFFFFFFCA, 1'b0, OL},
         '{OL, 3'b001, 32'd63, 32'h0,        32'h0,        1'b1, 7'h0},
         '{7'h33, 3'b010, 32'd0, 32'h0,      32'h0,        1'b1, 7'h0},
         '{OL, 3'b011, 32'd0,  32'h0,        32'h0,        1'b1, 7'h0},
         '{OL, 3'b010, 32'hFFFFFFFE, 32'h0,  32'h0,        1'b1, 7'h0},
         '{OS, 3'b010, 32'd61, 32'h12345678, 32'h0,        1'b1, 7'h0}
      };

      // Reset: outputs quiet even with both requests raised
      lsu_req_valid = 1'b1;
      if_req_valid  = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      check("rst_dp_ctrl", mem_dp_ctrl, 0);
      check("rst_lsu_ready", lsu_req_ready, 0);
      check("rst_if_ready", if_req_ready, 0);
      check("rst_rsp", {if_rsp_valid, lsu_rsp_valid, if_rsp_err, lsu_rsp_err}, 0);
      check("rst_data", if_rsp_data | lsu_rsp_data | mem_addr | mem_wr_data, 0);
      lsu_req_valid = 1'b0;
      if_req_valid  = 1'b0;
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 20; i++) begin
         ref_access(vt[i].op, vt[i].f3, vt[i].addr, vt[i].wd, ed, ee);
         do_txn(1'b0, vt[i].op, vt[i].f3, vt[i].addr, vt[i].wd, d, e, dpc);
         check($sformatf("vec%0d_data", i), d, vt[i].exp_d);
         check($sformatf("vec%0d_err", i), e, vt[i].exp_e);
         check($sformatf("vec%0d_dp", i), dpc, vt[i].exp_dp);
      end

      // IF word fetches: one legal, one running past the end
      ref_access(OL, 3'b010, 32'd8, 32'h0, ed, ee);
      do_txn(1'b1, OL, 3'b010, 32'd8, 32'h0, d, e, dpc);
      check("if_lw8_data", d, ed);
      check("if_lw8_err", e, 0);
      do_txn(1'b1, OL, 3'b010, 32'd61, 32'h0, d, e, dpc);
      check("if_lw61_err", e, 1);
      check("if_lw61_data", d, 0);
      check("if_lw61_dp", dpc, 0);

      // Both sides requesting continuously: streak limit and back-to-back cadence
      @(negedge clk);
      if_req_valid  = 1'b1;
      if_addr       = 32'd8;
      lsu_req_valid = 1'b1;
      lsu_opcode    = OL;
      lsu_funct3    = 3'b010;
      lsu_addr      = 32'd8;
      gcount        = 0;
      cyc           = -1;
      for (int c = 0; c < 60 && gcount < 15; c++) begin
         #1;
         check("one_ready", if_req_ready && lsu_req_ready, 0);
         if (cyc >= 0) begin
            check("b2b_rsp_cadence", if_rsp_valid | lsu_rsp_valid, cyc % 2);
            check("b2b_dp_only_issue", mem_dp_ctrl != 7'h0, cyc % 2 == 0);
            cyc++;
         end
         if (if_req_ready || lsu_req_ready) begin
            check($sformatf("grant%0d_is_if", gcount), if_req_ready, gcount % 5 == 4);
            gcount++;
            if (cyc < 0) cyc = 0;
         end
         @(negedge clk);
      end
      check("streak_grants_done", gcount, 15);
      if_req_valid  = 1'b0;
      lsu_req_valid = 1'b0;
      repeat (3) @(negedge clk);

      // Async reset in the ISSUE cycle of a store cancels it without a response
      lsu_req_valid = 1'b1;
      lsu_opcode    = OS;
      lsu_funct3    = 3'b010;
      lsu_addr      = 32'd0;
      lsu_wdata     = 32'h11223344;
      #1;
      check("rst_issue_accept", lsu_req_ready, 1);
      @(negedge clk);
      lsu_req_valid = 1'b0;
      #1;
      check("rst_issue_dp_before", mem_dp_ctrl, OS);
      #2 rst = 1'b1;
      #1;
      check("rst_issue_dp_async", mem_dp_ctrl, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (4) begin
         @(negedge clk);
         #1;
         check("rst_issue_no_rsp", if_rsp_valid | lsu_rsp_valid, 0);
      end
      do_txn(1'b0, OL, 3'b010, 32'd0, 32'h0, d, e, dpc);
      check("rst_issue_prior_contents", d, 32'h01020304);

      // Randomized traffic against the reference model
      for (int k = 0; k < 80; k++) begin
         rif = $urandom_range(0, 3) == 0;
         rop = rif ? OL : ($urandom_range(0, 7) == 0 ? 7'h33 : ($urandom_range(0, 1) == 1 ? OL : OS));
         rf3 = rif ? 3'b010 : 3'($urandom_range(0, 7));
         ra  = $urandom_range(0, 9) == 0 ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : 32'($urandom_range(0, 66));
         rwd = $urandom;
         ref_access(rop, rf3, ra, rwd, ed, ee);
         do_txn(rif, rop, rf3, ra, rwd, d, e, dpc);
         check($sformatf("rnd%0d_data", k), d, ed);
         check($sformatf("rnd%0d_err", k), e, ee);
         check($sformatf("rnd%0d_dp", k), dpc, ee ? 7'h0 : rop);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
